// File: rtl/cla_add_arbiter_pkg.sv
// Shared defaults for the shared-adder arbiter slice.
// Operand width, requester count, id width and pointer reset value.
package cla_add_arbiter_pkg;

  localparam int CLA_WIDTH   = 52;
  localparam int CLA_NUM_REQ = 4;
  localparam int CLA_ID_W    = $clog2(CLA_NUM_REQ);
  localparam int CLA_GRP     = 4;

  // Pointer starts on the last requester so requester 0 wins first.
  function automatic int ptr_rst(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/cla_add_arbiter_cla.sv
// Carry-lookahead adder: 4-bit groups with a group-level carry chain.
// Carry-in is fixed at zero; carry-out lands in the result MSB.
module cla_52bit
  import cla_add_arbiter_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o
);

  localparam int G  = CLA_GRP;
  localparam int NG = (WIDTH + G - 1) / G;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < NG; k++) begin
      gp[k] = 1'b1;
      for (int j = 0; j < G; j++) begin
        if (k * G + j < WIDTH) begin
          gg[k] = g[k*G+j] | (p[k*G+j] & gg[k]);
          gp[k] = gp[k] & p[k*G+j];
        end
      end
    end
  end

  always_comb begin
    gc    = '0;
    gc[0] = 1'b0;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
  end

  // Bit carries inside a group start from that group's lookahead carry.
  always_comb begin
    c = '0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < G; j++) begin
        if (k * G + j < WIDTH) begin
          if (j == 0) c[k*G] = gc[k];
          else c[k*G+j] = g[k*G+j-1] | (p[k*G+j-1] & c[k*G+j-1]);
        end
      end
    end
  end

  assign sum_o = {gc[NG], p ^ c};

endmodule

// File: rtl/cla_add_arbiter_rr.sv
// Round-robin grant for the shared adder.
// Searches from ptr+1 upward, wrapping, skipping idle requesters.
module cla_rr_arbiter
  import cla_add_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CLA_NUM_REQ,
  parameter int ID_W    = CLA_ID_W
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  logic found;
  int   k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int o = 1; o <= NUM_REQ; o++) begin
      k = (int'(ptr_i) + o) % NUM_REQ;
      if (en_i && !found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/cla_add_arbiter.sv
// One CLA adder shared round-robin between NUM_REQ requesters.
// Two-stage pipeline: operand reg feeds the adder, response reg holds the sum.
module cla_add_arbiter
  import cla_add_arbiter_pkg::*;
#(
  parameter int WIDTH   = CLA_WIDTH,
  parameter int NUM_REQ = CLA_NUM_REQ,
  parameter int ID_W    = CLA_ID_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_add1,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_add2,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [WIDTH:0]           o_rsp_result,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic                     o_busy
);

  logic             op_v_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [ID_W-1:0]  op_id_q;
  logic             rsp_v_q;
  logic [WIDTH:0]   rsp_res_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_d;

  logic               s2_adv;
  logic               s1_adv;
  logic               gnt_en;
  logic               xfer;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [WIDTH:0]     sum;

  assign s2_adv = !rsp_v_q || i_rsp_ready;
  assign s1_adv = !op_v_q || s2_adv;
  assign gnt_en = s1_adv && !i_rst;

  cla_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .en_i  (gnt_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // Grants only land on valid requesters, so any grant is a transfer.
  assign xfer  = |gnt;
  assign ptr_d = xfer ? gnt_idx : ptr_q;
  assign sel_a = i_req_add1[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_b = i_req_add2[int'(gnt_idx)*WIDTH +: WIDTH];

  cla_52bit #(
    .WIDTH (WIDTH)
  ) u_cla (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .sum_o (sum)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_v_q    <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_id_q   <= '0;
      rsp_v_q   <= 1'b0;
      rsp_res_q <= '0;
      rsp_id_q  <= '0;
      ptr_q     <= ID_W'(ptr_rst(NUM_REQ));
    end else begin
      ptr_q <= ptr_d;
      if (s2_adv) begin
        rsp_v_q <= op_v_q;
        if (op_v_q) begin
          rsp_res_q <= sum;
          rsp_id_q  <= op_id_q;
        end
      end
      if (s1_adv) begin
        op_v_q <= xfer;
        if (xfer) begin
          op_a_q  <= sel_a;
          op_b_q  <= sel_b;
          op_id_q <= gnt_idx;
        end
      end
    end
  end

  assign o_req_ready  = gnt;
  assign o_rsp_valid  = rsp_v_q && !i_rst;
  assign o_rsp_result = rsp_res_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_busy       = (op_v_q || rsp_v_q) && !i_rst;

endmodule
